// File: rtl/branch_pkg.sv
// Shared encodings and predictor-counter helpers for the branch resolve unit.
package branch_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    F3_BEQ   = 3'b000,
    F3_BNE   = 3'b001,
    F3_RSVD2 = 3'b010,
    F3_RSVD3 = 3'b011,
    F3_BLT   = 3'b100,
    F3_BGE   = 3'b101,
    F3_BLTU  = 3'b110,
    F3_BGEU  = 3'b111
  } funct3_e;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_RESET = 2'b01;

  // Two-bit saturating counter step: toward 3 on taken, toward 0 otherwise.
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Operand comparator: equality plus signed and unsigned less-than.
module branch_cmp #(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  output logic              eq,
  output logic              lt,
  output logic              ltu
);

  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves conditional branches one cycle after acceptance and trains a
// bimodal table of 2-bit counters that also serves fetch-stage predictions.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int BHT_ENTRIES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] lookup_pc_i,
  output logic              pred_taken_o,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [DWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] imm_i,
  input  logic [DWIDTH-1:0] rs1_i,
  input  logic [DWIDTH-1:0] rs2_i,
  input  logic              pred_taken_i,
  output logic              res_valid_o,
  output logic              taken_o,
  output logic [DWIDTH-1:0] target_o,
  output logic              mispredict_o,
  output logic              breq_o,
  output logic              brlt_o,
  output logic              illegal_o
);

  localparam int IDXW = $clog2(BHT_ENTRIES);

  ctr_t bht [BHT_ENTRIES];

  logic [IDXW-1:0] lookup_idx;
  logic [IDXW-1:0] upd_idx;
  logic            accept;
  logic            eq;
  logic            lt;
  logic            ltu;
  logic            lt_sel;
  logic            taken_c;
  logic            illegal_c;
  logic            unused_pc_bits;

  assign lookup_idx     = lookup_pc_i[IDXW+1:2];
  assign upd_idx        = pc_i[IDXW+1:2];
  assign unused_pc_bits = ^{lookup_pc_i[DWIDTH-1:IDXW+2], lookup_pc_i[1:0]};

  // Combinational read of the registered array gives read-before-write
  // behaviour when lookup and update hit the same entry.
  assign pred_taken_o = bht[lookup_idx][1];

  assign accept = valid_i & ~flush_i & (opcode_i == OPC_BRANCH);

  branch_cmp #(.DWIDTH(DWIDTH)) u_cmp (
    .a   (rs1_i),
    .b   (rs2_i),
    .eq  (eq),
    .lt  (lt),
    .ltu (ltu)
  );

  assign lt_sel = funct3_i[1] ? ltu : lt;

  always_comb begin
    taken_c   = 1'b0;
    illegal_c = 1'b0;
    case (funct3_e'(funct3_i))
      F3_BEQ:  taken_c = eq;
      F3_BNE:  taken_c = ~eq;
      F3_BLT:  taken_c = lt;
      F3_BGE:  taken_c = ~lt;
      F3_BLTU: taken_c = ltu;
      F3_BGEU: taken_c = ~ltu;
      default: illegal_c = 1'b1;
    endcase
  end

  // Pulse flags drop whenever nothing was accepted; target and compare
  // flags keep their last accepted values.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_o  <= 1'b0;
      taken_o      <= 1'b0;
      mispredict_o <= 1'b0;
      illegal_o    <= 1'b0;
      target_o     <= '0;
      breq_o       <= 1'b0;
      brlt_o       <= 1'b0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_RESET;
    end else begin
      res_valid_o  <= accept;
      taken_o      <= accept & taken_c;
      mispredict_o <= accept & (taken_c ^ pred_taken_i);
      illegal_o    <= accept & illegal_c;
      if (accept) begin
        target_o <= pc_i + imm_i;
        breq_o   <= eq;
        brlt_o   <= lt_sel;
      end
      if (accept && !illegal_c) bht[upd_idx] <= ctr_next(bht[upd_idx], taken_c);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed, table-driven bench for branch_resolve_unit with hand sequences
// for counter saturation, read-before-write, flush and mid-stream reset.
module tb_branch_resolve_unit;

  localparam logic [6:0] OPB = 7'b1100011;
  localparam logic [6:0] OPI = 7'b0010011;

  typedef struct {
    string       name;
    logic        valid;
    logic        flush;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        pred;
    logic        e_rv;
    logic        e_taken;
    logic        e_mis;
    logic        e_breq;
    logic        e_brlt;
    logic        e_ill;
    logic        chk_flags;
    logic [31:0] e_target;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lookup_pc_i;
  logic        pred_taken_o;
  logic        valid_i;
  logic        flush_i;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [31:0] pc_i;
  logic [31:0] imm_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        pred_taken_i;
  logic        res_valid_o;
  logic        taken_o;
  logic [31:0] target_o;
  logic        mispredict_o;
  logic        breq_o;
  logic        brlt_o;
  logic        illegal_o;

  int num_checks = 0;
  int num_fail   = 0;

  vec_t vecs[11];

  branch_resolve_unit #(.DWIDTH(32), .BHT_ENTRIES(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .lookup_pc_i  (lookup_pc_i),
    .pred_taken_o (pred_taken_o),
    .valid_i      (valid_i),
    .flush_i      (flush_i),
    .opcode_i     (opcode_i),
    .funct3_i     (funct3_i),
    .pc_i         (pc_i),
    .imm_i        (imm_i),
    .rs1_i        (rs1_i),
    .rs2_i        (rs2_i),
    .pred_taken_i (pred_taken_i),
    .res_valid_o  (res_valid_o),
    .taken_o      (taken_o),
    .target_o     (target_o),
    .mispredict_o (mispredict_o),
    .breq_o       (breq_o),
    .brlt_o       (brlt_o),
    .illegal_o    (illegal_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkVec(
    input string name, input logic valid, input logic flush,
    input logic [6:0] opc, input logic [2:0] f3,
    input logic [31:0] pc, input logic [31:0] imm,
    input logic [31:0] rs1, input logic [31:0] rs2, input logic pred,
    input logic rv, input logic tk, input logic mis,
    input logic breq, input logic brlt, input logic ill,
    input logic chk, input logic [31:0] tgt);
    vec_t v;
    v.name = name; v.valid = valid; v.flush = flush; v.opcode = opc;
    v.funct3 = f3; v.pc = pc; v.imm = imm; v.rs1 = rs1; v.rs2 = rs2;
    v.pred = pred; v.e_rv = rv; v.e_taken = tk; v.e_mis = mis;
    v.e_breq = breq; v.e_brlt = brlt; v.e_ill = ill; v.chk_flags = chk;
    v.e_target = tgt;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic setInputs(input vec_t v);
    valid_i      = v.valid;
    flush_i      = v.flush;
    opcode_i     = v.opcode;
    funct3_i     = v.funct3;
    pc_i         = v.pc;
    imm_i        = v.imm;
    rs1_i        = v.rs1;
    rs2_i        = v.rs2;
    pred_taken_i = v.pred;
  endtask

  task automatic idle();
    valid_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    setInputs(v);
    @(posedge clk);
    #1;
  endtask

  task automatic checkVec(input vec_t v);
    checkOutput({v.name, ".res_valid"},  {31'b0, res_valid_o},  {31'b0, v.e_rv});
    checkOutput({v.name, ".taken"},      {31'b0, taken_o},      {31'b0, v.e_taken});
    checkOutput({v.name, ".mispredict"}, {31'b0, mispredict_o}, {31'b0, v.e_mis});
    checkOutput({v.name, ".illegal"},    {31'b0, illegal_o},    {31'b0, v.e_ill});
    checkOutput({v.name, ".target"},     target_o,              v.e_target);
    if (v.chk_flags) begin
      checkOutput({v.name, ".breq"}, {31'b0, breq_o}, {31'b0, v.e_breq});
      checkOutput({v.name, ".brlt"}, {31'b0, brlt_o}, {31'b0, v.e_brlt});
    end
  endtask

  task automatic checkPred(input string name, input logic [31:0] pc, input logic exp);
    lookup_pc_i = pc;
    #1;
    checkOutput(name, {31'b0, pred_taken_o}, {31'b0, exp});
  endtask

  initial begin
    vec_t v;

    //                 name     vld flsh opc  f3     pc            imm           rs1           rs2           pr  rv tk ms eq lt il ck target
    vecs[0]  = mkVec("beq_eq",   1, 0, OPB, 3'b000, 32'h00000100, 32'h00000008, 32'd10,       32'd10,       0,  1, 1, 1, 1, 0, 0, 1, 32'h00000108);
    vecs[1]  = mkVec("blt_neg",  1, 0, OPB, 3'b100, 32'h00000104, 32'h00000010, 32'hFFFFFFFF, 32'd1,        0,  1, 1, 1, 0, 1, 0, 1, 32'h00000114);
    vecs[2]  = mkVec("bltu_neg", 1, 0, OPB, 3'b110, 32'h00000108, 32'h00000010, 32'hFFFFFFFF, 32'd1,        1,  1, 0, 1, 0, 0, 0, 1, 32'h00000118);
    vecs[3]  = mkVec("bne_wrap", 1, 0, OPB, 3'b001, 32'hFFFFFFF0, 32'h00000020, 32'd5,        32'd5,        0,  1, 0, 0, 1, 0, 0, 1, 32'h00000010);
    vecs[4]  = mkVec("bge_neg",  1, 0, OPB, 3'b101, 32'h00000110, 32'h00000004, 32'hFFFFFFFB, 32'd3,        1,  1, 0, 1, 0, 1, 0, 1, 32'h00000114);
    vecs[5]  = mkVec("bgeu_big", 1, 0, OPB, 3'b111, 32'h00000114, 32'hFFFFFFFC, 32'hFFFFFFFB, 32'd3,        1,  1, 1, 0, 0, 0, 0, 1, 32'h00000110);
    vecs[6]  = mkVec("illegal",  1, 0, OPB, 3'b010, 32'h00000118, 32'h00000004, 32'd1,        32'd2,        0,  1, 0, 0, 0, 0, 1, 0, 32'h0000011C);
    vecs[7]  = mkVec("bltu_pos", 1, 0, OPB, 3'b110, 32'h00000128, 32'h00000008, 32'd1,        32'd2,        1,  1, 1, 0, 0, 1, 0, 1, 32'h00000130);
    vecs[8]  = mkVec("flushed",  1, 1, OPB, 3'b000, 32'h0000011C, 32'h00000040, 32'd10,       32'd10,       0,  0, 0, 0, 0, 1, 0, 1, 32'h00000130);
    vecs[9]  = mkVec("nonbr",    1, 0, OPI, 3'b000, 32'h00000120, 32'h00000040, 32'd10,       32'd10,       0,  0, 0, 0, 0, 1, 0, 1, 32'h00000130);
    vecs[10] = mkVec("idle",     0, 0, OPB, 3'b000, 32'h00000124, 32'h00000040, 32'd10,       32'd10,       0,  0, 0, 0, 0, 1, 0, 1, 32'h00000130);

    reset = 1'b1;
    lookup_pc_i = '0;
    setInputs(vecs[10]);
    repeat (2) @(posedge clk);
    #1;
    checkVec(mkVec("reset", 0, 0, OPB, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0));
    for (int i = 0; i < 16; i++) checkPred($sformatf("reset_pred%0d", i), 32'(i) << 2, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      checkVec(vecs[i]);
    end

    idle();
    checkPred("bht_idx0",  32'h00000100, 1'b1);
    checkPred("bht_idx1",  32'h00000104, 1'b1);
    checkPred("bht_idx2",  32'h00000108, 1'b0);
    checkPred("bht_idx12", 32'hFFFFFFF0, 1'b0);
    checkPred("bht_idx4",  32'h00000110, 1'b0);
    checkPred("bht_idx5",  32'h00000114, 1'b1);
    checkPred("bht_idx6",  32'h00000118, 1'b0);
    checkPred("bht_idx7",  32'h0000011C, 1'b0);
    checkPred("bht_idx8",  32'h00000120, 1'b0);
    checkPred("bht_idx10", 32'h00000128, 1'b1);

    // Entries untouched by illegal/flushed/non-branch must still be 01: one taken step makes them predict taken.
    for (int i = 0; i < 3; i++) begin
      v = mkVec("untouched", 1, 0, OPB, 3'b000, 32'h00000118 + 32'(i) * 4, 32'h0, 32'd7, 32'd7, 0,
                1, 1, 1, 1, 0, 0, 1, 32'h00000118 + 32'(i) * 4);
      applyStimulus(v);
      checkVec(v);
    end
    idle();
    checkPred("after_illegal_idx6", 32'h00000118, 1'b1);
    checkPred("after_flush_idx7",   32'h0000011C, 1'b1);
    checkPred("after_nonbr_idx8",   32'h00000120, 1'b1);

    // Four taken branches at index 9, lookup concurrent with updates 1 and 3.
    v = mkVec("sat_taken", 1, 0, OPB, 3'b000, 32'h00000124, 32'h4, 32'd3, 32'd3, 0, 1, 1, 1, 1, 0, 0, 1, 32'h00000128);
    for (int i = 0; i < 4; i++) begin
      setInputs(v);
      lookup_pc_i = 32'h00000124;
      #1;
      if (i == 0) checkOutput("rbw_first", {31'b0, pred_taken_o}, 32'd0);
      if (i == 2) checkOutput("rbw_third", {31'b0, pred_taken_o}, 32'd1);
      @(posedge clk);
      #1;
      checkVec(v);
      checkOutput($sformatf("sat_pred%0d", i), {31'b0, pred_taken_o}, 32'd1);
    end
    v = mkVec("sat_nt", 1, 0, OPB, 3'b000, 32'h00000124, 32'h4, 32'd1, 32'd2, 0, 1, 0, 0, 0, 1, 0, 1, 32'h00000128);
    applyStimulus(v);
    checkVec(v);
    checkOutput("sat_down1", {31'b0, pred_taken_o}, 32'd1);
    applyStimulus(v);
    checkOutput("sat_down2", {31'b0, pred_taken_o}, 32'd0);

    // Index 2 sits at 00: a not-taken must hold it, so one taken reaches only 01.
    v = mkVec("floor_nt", 1, 0, OPB, 3'b000, 32'h00000108, 32'h0, 32'd1, 32'd2, 0, 1, 0, 0, 0, 1, 0, 1, 32'h00000108);
    applyStimulus(v);
    checkVec(v);
    v = mkVec("floor_tk", 1, 0, OPB, 3'b000, 32'h00000108, 32'h0, 32'd1, 32'd1, 0, 1, 1, 1, 1, 0, 0, 1, 32'h00000108);
    applyStimulus(v);
    checkVec(v);
    idle();
    checkPred("floor_pred", 32'h00000108, 1'b0);

    // A registered result is cleared by a flush at the following edge.
    v = mkVec("pre_flush", 1, 0, OPB, 3'b100, 32'h0000012C, 32'h8, 32'hFFFFFFFF, 32'd0, 0, 1, 1, 1, 0, 1, 0, 1, 32'h00000134);
    applyStimulus(v);
    checkVec(v);
    v = mkVec("do_flush", 0, 1, OPB, 3'b100, 32'h0000012C, 32'h8, 32'hFFFFFFFF, 32'd0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h00000134);
    applyStimulus(v);
    checkVec(v);

    // Reset mid-stream with a valid branch present.
    reset = 1'b1;
    v = mkVec("reset_mid", 1, 0, OPB, 3'b000, 32'h00000130, 32'h10, 32'd4, 32'd4, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
    applyStimulus(v);
    checkVec(v);
    idle();
    for (int i = 0; i < 16; i++) checkPred($sformatf("reset_mid_pred%0d", i), 32'(i) << 2, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter DWIDTH, default 32, SHALL set the width of operands, PC, immediate and target.
REQ-002 Parameter BHT_ENTRIES, default 16, SHALL set the number of 2-bit predictor counters; it SHALL be a power of two, at least 2.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 lookup_pc_i  in  DWIDTH  fetch-stage PC for prediction lookup.
REQ-006 pred_taken_o  out  1  combinational prediction for lookup_pc_i.
REQ-007 valid_i  in  1  resolve-stage instruction present this cycle.
REQ-008 flush_i  in  1  cancels the resolve-stage instruction and any registered result.
REQ-009 opcode_i  in  7  instruction opcode.
REQ-010 funct3_i  in  3  branch condition select.
REQ-011 pc_i  in  DWIDTH  PC of the resolving instruction.
REQ-012 imm_i  in  DWIDTH  sign-extended B-type immediate.
REQ-013 rs1_i, rs2_i  in  DWIDTH each  source operands.
REQ-014 pred_taken_i  in  1  prediction that travelled with the instruction.
REQ-015 res_valid_o  out  1  registered result valid, one-cycle pulse per resolved branch.
REQ-016 taken_o  out  1  registered branch outcome.
REQ-017 target_o  out  DWIDTH  registered pc_i + imm_i.
REQ-018 mispredict_o  out  1  registered, taken_o differs from the captured pred_taken_i.
REQ-019 breq_o, brlt_o  out  1 each  registered equality and less-than flags (signed or unsigned per funct3).
REQ-020 illegal_o  out  1  registered, B-type opcode with reserved funct3.

Function
REQ-021 Accept condition SHALL be valid_i & ~flush_i & opcode_i==1100011; only accepted instructions SHALL produce a result or update the BHT.
REQ-022 funct3 000/001/100/101/110/111 SHALL select BEQ/BNE/BLT/BGE/BLTU/BGEU; 100/101 signed compare; 110/111 unsigned compare.
REQ-023 For funct3 010/011, taken=0, illegal=1, res_valid=1, and the BHT SHALL NOT be updated.
REQ-024 Latency SHALL be exactly one cycle: results of an instruction accepted at edge N are visible after edge N, held for one cycle only.
REQ-025 res_valid_o, taken_o, mispredict_o and illegal_o SHALL be 0 in any cycle without an accepted instruction at the preceding edge; target_o, breq_o and brlt_o SHALL hold their last values.
REQ-026 target_o SHALL be (pc_i + imm_i) mod 2^DWIDTH; overflow SHALL wrap silently.
REQ-027 BHT index SHALL be pc[log2(BHT_ENTRIES)+1:2] for both lookup and update; pred_taken_o SHALL be counter bit 1.
REQ-028 On an accepted legal branch the indexed counter SHALL increment if taken, decrement if not, saturating at 3 and 0.
REQ-029 Lookup and update to the same index in the same cycle: pred_taken_o SHALL reflect the pre-update value (read-before-write).
REQ-030 flush_i high while a result is registered SHALL clear res_valid_o, taken_o, mispredict_o and illegal_o at the next edge; BHT updates already made SHALL stand.
REQ-031 Non-branch opcodes SHALL produce no result, with every flag output 0.

Reset
REQ-032 While reset is high at an edge: all registered outputs SHALL be 0 and every BHT counter SHALL be 2'b01 (weakly not-taken); reset SHALL override valid_i and flush_i.
REQ-033 A branch accepted in the same cycle as reset SHALL be discarded, with no result and no BHT update.

Structure
REQ-034 Package branch_pkg SHALL hold the B-type opcode, the funct3 encodings, the counter type, and the counter reset value.
REQ-035 A combinational sub-module branch_cmp SHALL compute eq, lt-signed and lt-unsigned; the BHT and result registers SHALL live in the top module.

Verification
REQ-036 BEQ with rs1=rs2=10, pred 0 -> next cycle res_valid=1, taken=1, breq=1, mispredict=1; counter 01 goes to 10.
REQ-037 BLT rs1=-1 (0xFFFFFFFF), rs2=1 -> taken=1; BLTU with the same operands -> taken=0, brlt=0.
REQ-038 pc=0xFFFFFFF0, imm=0x20 -> target_o=0x00000010.
REQ-039 Four taken branches at one index -> counter saturates at 3; a lookup in the same cycle as the 3rd update returns the pre-update prediction.
REQ-040 funct3=010 -> illegal=1, taken=0, no BHT change; valid_i with flush_i=1 -> res_valid=0, no BHT change.
REQ-041 reset asserted mid-stream with valid_i=1 -> all outputs 0 and pred_taken_o=0 for every index.
